gnr_attractor_ctrl: RTL

Sequencing controller for one gene-regulatory-network node array (N_NODES two-register nodes, each with a slow copy s0 and a fast copy s1). It loads a seed state into every node and steps the network with a Floyd tortoise/hare schedule until the two copies meet. It then measures the attractor period by stepping only the fast copy. It sits between the host/seed source and the node array, owning every node control strobe.

---
 rtl/gnr_attractor_ctrl_if.sv | 31 +++
 rtl/gnr_attractor_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/gnr_attractor_ctrl_if.sv
// gnr_attractor_ctrl_if: host and node-array signals of the attractor controller
// master: host/seed source plus node array (drives start, seed, max_steps, nos_s0/1)
// slave : the controller (drives node strobes, status and results)
interface gnr_attractor_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [N_NODES-1:0] seed;
  logic [CNT_W-1:0]   max_steps;
  logic               reset_nos;
  logic [N_NODES-1:0] init_state;
  logic               start_s0;
  logic               start_s1;
  logic [N_NODES-1:0] nos_s0;
  logic [N_NODES-1:0] nos_s1;
  logic               busy;
  logic               done;
  logic               found;
  logic               timeout;
  logic [CNT_W-1:0]   meet_steps;
  logic [CNT_W-1:0]   period;
  modport master (
    output start, seed, max_steps, nos_s0, nos_s1,
    input  reset_nos, init_state, start_s0, start_s1, busy, done, found, timeout, meet_steps, period
  );
  modport slave (
    input  start, seed, max_steps, nos_s0, nos_s1,
    output reset_nos, init_state, start_s0, start_s1, busy, done, found, timeout, meet_steps, period
  );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: Floyd tortoise/hare sequencer finding a GRN attractor and its period
// clk, rst_n (async active-low); bus: gnr_attractor_ctrl_if.slave
//   start/seed/max_steps in, busy/done/found/timeout/meet_steps/period out,
//   reset_nos/init_state/start_s0/start_s1 out to nodes, nos_s0/nos_s1 in from nodes
module gnr_attractor_ctrl #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                rst_n,
  gnr_attractor_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, PERIOD = 3'd3, DONE = 3'd4;
  logic [2:0]         state_q, state_d;
  logic [N_NODES-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]   max_q, max_d, steps_q, steps_d, p_q, p_d, meet_q, meet_d, period_q, period_d;
  logic               found_q, found_d, timeout_q, timeout_d;
  logic               eq, match, run_go, per_hit, per_go;
  assign eq      = bus.nos_s0 == bus.nos_s1;
  // slow copy is at ceil(k/2) after k fast strobes, so only even k compare like-for-like
  assign match   = state_q == RUN && !steps_q[0] && steps_q >= CNT_W'(2) && eq;
  assign run_go  = state_q == RUN && !match && steps_q != max_q;
  assign per_hit = state_q == PERIOD && p_q != '0 && eq;
  assign per_go  = state_q == PERIOD && !per_hit && p_q != max_q;
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    max_d     = max_q;
    steps_d   = steps_q;
    p_d       = p_q;
    meet_d    = meet_q;
    period_d  = period_q;
    found_d   = found_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (bus.start) begin
        seed_d    = bus.seed;
        max_d     = bus.max_steps == '0 ? CNT_W'(1) : bus.max_steps;
        found_d   = 1'b0;
        timeout_d = 1'b0;
        meet_d    = '0;
        period_d  = '0;
        state_d   = LOAD;
      end
      LOAD: begin
        steps_d = '0;
        state_d = RUN;
      end
      RUN: if (match) begin
        meet_d  = steps_q;
        p_d     = '0;
        state_d = PERIOD;
      end else if (!run_go) begin
        timeout_d = 1'b1;
        state_d   = DONE;
      end else steps_d = steps_q + CNT_W'(1);
      PERIOD: if (per_hit) begin
        period_d = p_q;
        found_d  = 1'b1;
        state_d  = DONE;
      end else if (!per_go) begin
        timeout_d = 1'b1;
        state_d   = DONE;
      end else p_d = p_q + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      max_q     <= '0;
      steps_q   <= '0;
      p_q       <= '0;
      meet_q    <= '0;
      period_q  <= '0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      max_q     <= max_d;
      steps_q   <= steps_d;
      p_q       <= p_d;
      meet_q    <= meet_d;
      period_q  <= period_d;
      found_q   <= found_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.reset_nos  = state_q == LOAD;
  assign bus.init_state = seed_q;
  assign bus.start_s0   = run_go;
  assign bus.start_s1   = run_go || per_go;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = state_q == DONE;
  assign bus.found      = found_q;
  assign bus.timeout    = timeout_q;
  assign bus.meet_steps = meet_q;
  assign bus.period     = period_q;
endmodule
